// File: rtl/cam_pixel_capture.sv
// Camera pixel capture: assembles sensor byte pairs into pixels, optional 2x/4x decimation,
// linear frame-buffer addressing with write strobes, and frame/line integrity status.
module cam_pixel_capture #(
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned DEPTH    = 307200
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fmt,
  input  logic [1:0]        decim,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(2 * H_ACTIVE + 1) + 1;
  localparam logic [CNT_W-1:0]  LINE_BYTES = CNT_W'(2 * H_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic              vsync_r, href_r, vsync_q, href_q;
  logic [7:0]        d_r, hi_q;
  logic [1:0]        state_q, decim_q, x_q, y_q, mask;
  logic              fmt_q, phase_q, full_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  dout_q, pix;
  logic              we_q, frame_done_q, line_err_q, overflow_q;
  logic [7:0]        frame_cnt_q;

  logic vsync_fall, vsync_rise, active, line_end, byte_en, pix_en, keep;

  assign vsync_fall = vsync_q & ~vsync_r;
  assign vsync_rise = ~vsync_q & vsync_r;
  assign active     = (state_q == ACTIVE);
  // A vsync rise during an active line closes that line in the same cycle.
  assign line_end   = active & ((href_q & ~href_r) | (vsync_rise & href_r));
  assign byte_en    = active & href_r & ~line_end;
  assign pix_en     = byte_en & phase_q;

  always_comb begin
    mask = 2'b11;
    case (decim_q)
      2'd0:    mask = 2'b00;
      2'd1:    mask = 2'b01;
      default: mask = 2'b11;
    endcase
  end

  assign keep = ((x_q & mask) == 2'b00) && ((y_q & mask) == 2'b00);

  if (PIX_W == 16) begin : g_pix16
    assign pix = fmt_q ? {hi_q[7:3], hi_q[7:2], hi_q[7:3]} : {hi_q, d_r};
  end else begin : g_pix12
    assign pix = fmt_q ? {3{hi_q[7:4]}} : {hi_q[7:4], hi_q[2:0], d_r[7], d_r[4:1]};
    logic unused_pix;
    assign unused_pix = ^{hi_q[3], d_r[6:5], d_r[0]};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      d_r     <= 8'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      href_r  <= href;
      d_r     <= d;
      vsync_q <= vsync_r;
      href_q  <= href_r;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fmt_q        <= 1'b0;
      decim_q      <= 2'd0;
      hi_q         <= 8'd0;
      phase_q      <= 1'b0;
      x_q          <= 2'd0;
      y_q          <= 2'd0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      line_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;

      // Address advances the cycle after each write and parks on the last word.
      if (we_q) begin
        if (addr_q == LAST_ADDR) full_q <= 1'b1;
        else                     addr_q <= addr_q + ADDR_W'(1);
      end

      if (line_end) begin
        x_q     <= 2'd0;
        phase_q <= 1'b0;
        cnt_q   <= '0;
        if (cnt_q != '0) begin
          y_q        <= y_q + 2'd1;
          line_err_q <= (cnt_q != LINE_BYTES);
        end
      end else if (byte_en) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_q <= d_r;
        end else begin
          x_q <= x_q + 2'd1;
          if (keep && !full_q) begin
            we_q   <= 1'b1;
            dout_q <= pix;
          end else if (keep) begin
            overflow_q <= 1'b1;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (vsync_fall && enable) begin
            state_q    <= ACTIVE;
            fmt_q      <= fmt;
            decim_q    <= decim;
            addr_q     <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            x_q        <= 2'd0;
            y_q        <= 2'd0;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
          end
        end
        ACTIVE: begin
          if (vsync_rise) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_err   = line_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture: instance a (12-bit, short lines, roomy buffer) and
// instance b (16-bit, 8-word buffer) share one stimulus bus steered by sel.
module tb_cam_pixel_capture;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       fmt = 1'b0;
  logic [1:0] decim = 2'd0;
  logic       vsync = 1'b1;
  logic       href = 1'b0;
  logic [7:0] d = 8'd0;
  logic       sel = 1'b0;

  logic vsync_a, href_a, vsync_b, href_b;
  assign vsync_a = sel ? 1'b1 : vsync;
  assign href_a  = sel ? 1'b0 : href;
  assign vsync_b = sel ? vsync : 1'b1;
  assign href_b  = sel ? href : 1'b0;

  logic [7:0]  addr_a, fc_a;
  logic [11:0] dout_a;
  logic        we_a, fd_a, le_a, ov_a;
  logic [3:0]  addr_b;
  logic [15:0] dout_b;
  logic [7:0]  fc_b;
  logic        we_b, fd_b, le_b, ov_b;

  cam_pixel_capture #(.PIX_W(12), .ADDR_W(8), .H_ACTIVE(8), .DEPTH(64)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .fmt(fmt), .decim(decim),
    .vsync(vsync_a), .href(href_a), .d(d),
    .addr(addr_a), .dout(dout_a), .we(we_a), .frame_done(fd_a), .frame_cnt(fc_a),
    .line_err(le_a), .overflow(ov_a)
  );

  cam_pixel_capture #(.PIX_W(16), .ADDR_W(4), .H_ACTIVE(4), .DEPTH(8)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .fmt(fmt), .decim(decim),
    .vsync(vsync_b), .href(href_b), .d(d),
    .addr(addr_b), .dout(dout_b), .we(we_b), .frame_done(fd_b), .frame_cnt(fc_b),
    .line_err(le_b), .overflow(ov_b)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;
  int n_we_a = 0, n_fd_a = 0, n_le_a = 0;
  int n_we_b = 0, n_fd_b = 0, n_le_b = 0;
  int base_we, base_fd, base_le;
  logic [7:0] exp_fc;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each write strobe is matched against the next expected {addr, data}.
  always @(negedge pclk) begin
    logic [31:0] e;
    if (we_a === 1'b1) begin
      n_we_a++;
      if (q_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we_a: got write addr %0d expected no write", addr_a);
      end else begin
        e = q_a.pop_front();
        check("write_a", {16'(addr_a), 16'(dout_a)}, e);
      end
    end
    if (we_b === 1'b1) begin
      n_we_b++;
      if (q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we_b: got write addr %0d expected no write", addr_b);
      end else begin
        e = q_b.pop_front();
        check("write_b", {16'(addr_b), 16'(dout_b)}, e);
      end
    end
    if (fd_a === 1'b1) n_fd_a++;
    if (le_a === 1'b1) n_le_a++;
    if (fd_b === 1'b1) n_fd_b++;
    if (le_b === 1'b1) n_le_b++;
  end

  task automatic run_frame(input bit inst, input int nlines, input int nbytes,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] px,
                           input int mask, input int depth, input bit model);
    int a = 0;
    base_we = inst ? n_we_b : n_we_a;
    base_fd = inst ? n_fd_b : n_fd_a;
    base_le = inst ? n_le_b : n_le_a;
    if (model) begin
      for (int y = 0; y < nlines; y++)
        for (int x = 0; x < nbytes / 2; x++)
          if (((x & mask) == 0) && ((y & mask) == 0)) begin
            if (a < depth) begin
              if (inst) q_b.push_back({16'(a), px});
              else      q_a.push_back({16'(a), px});
            end
            a++;
          end
    end
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int y = 0; y < nlines; y++) begin
      for (int i = 0; i < nbytes; i++) begin
        href = 1'b1;
        d = (i % 2 == 0) ? b0 : b1;
        @(negedge pclk);
      end
      href = 1'b0;
      repeat (3) @(negedge pclk);
    end
    vsync = 1'b1;
    repeat (6) @(negedge pclk);
  endtask

  task automatic post(input string tag, input bit inst, input int ewe, input int ele,
                      input int efd, input int eaddr, input int eov, input int efc);
    check({tag, "_we_count"}, (inst ? n_we_b : n_we_a) - base_we, ewe);
    check({tag, "_line_err"}, (inst ? n_le_b : n_le_a) - base_le, ele);
    check({tag, "_frame_done"}, (inst ? n_fd_b : n_fd_a) - base_fd, efd);
    check({tag, "_addr"}, inst ? 32'(addr_b) : 32'(addr_a), eaddr);
    check({tag, "_overflow"}, inst ? 32'(ov_b) : 32'(ov_a), eov);
    check({tag, "_frame_cnt"}, inst ? 32'(fc_b) : 32'(fc_a), efc);
    check({tag, "_drained"}, inst ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge pclk);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_dout", 32'(dout_a), 0);
    check("rst_flags", {28'd0, we_a, fd_a, le_a, ov_a}, 0);
    check("rst_frame_cnt", 32'(fc_a), 0);
    check("rst_b", {we_b, fd_b, le_b, ov_b, 12'd0, dout_b}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge pclk);

    // RGB565 source into RGB444: F8,1F -> F0F; short lines flag line_err.
    run_frame(0, 2, 4, 8'hF8, 8'h1F, 16'h0F0F, 0, 64, 1);
    post("t1", 0, 4, 2, 1, 4, 0, 1);
    // YUYV grey, 2x decimation, full-length lines.
    fmt = 1'b1; decim = 2'd1;
    run_frame(0, 4, 16, 8'hA5, 8'h80, 16'h0AAA, 1, 64, 1);
    post("t2", 0, 8, 0, 1, 8, 0, 2);
    // 4x decimation; decim 3 behaves the same. 12,34 -> 14A.
    fmt = 1'b0; decim = 2'd2;
    run_frame(0, 4, 16, 8'h12, 8'h34, 16'h014A, 3, 64, 1);
    post("t2_d4", 0, 2, 0, 1, 2, 0, 3);
    decim = 2'd3;
    run_frame(0, 4, 16, 8'h12, 8'h34, 16'h014A, 3, 64, 1);
    post("t2_d3", 0, 2, 0, 1, 2, 0, 4);
    // Odd byte count: half pixel dropped, line_err once.
    decim = 2'd0;
    run_frame(0, 1, 15, 8'hF8, 8'h1F, 16'h0F0F, 0, 64, 1);
    post("t3", 0, 7, 1, 1, 7, 0, 5);
    // Disabled at frame start: nothing written, counter untouched.
    enable = 1'b0;
    run_frame(0, 1, 16, 8'hF8, 8'h1F, 16'h0F0F, 0, 64, 0);
    post("t5_disabled", 0, 0, 0, 0, 7, 0, 5);
    enable = 1'b1;
    exp_fc = 8'd5;
    while (exp_fc != 8'd255) begin
      run_frame(0, 0, 0, 8'h00, 8'h00, 16'h0000, 0, 64, 0);
      exp_fc = exp_fc + 8'd1;
    end
    check("t5_cnt_255", 32'(fc_a), 255);
    run_frame(0, 0, 0, 8'h00, 8'h00, 16'h0000, 0, 64, 0);
    check("t5_cnt_wrap", 32'(fc_a), 0);

    // Instance b: 8-word buffer overflows on a 10-pixel frame.
    sel = 1'b1;
    repeat (2) @(negedge pclk);
    run_frame(1, 5, 4, 8'hAB, 8'hCD, 16'hABCD, 0, 8, 1);
    post("t4", 1, 8, 5, 1, 7, 1, 1);
    repeat (4) @(negedge pclk);
    check("t4_ov_held", 32'(ov_b), 1);
    fmt = 1'b1;
    run_frame(1, 1, 8, 8'hA5, 8'h00, 16'hA534, 0, 8, 1);
    post("t4_next", 1, 4, 0, 1, 4, 0, 2);

    // Reset mid-line on instance a.
    sel = 1'b0; fmt = 1'b0;
    repeat (2) @(negedge pclk);
    q_a.push_back({16'd0, 16'h0F0F});
    q_a.push_back({16'd1, 16'h0F0F});
    q_a.push_back({16'd2, 16'h0F0F});
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 7; i++) begin
      href = 1'b1;
      d = (i % 2 == 0) ? 8'hF8 : 8'h1F;
      @(negedge pclk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_addr_zero", 32'(addr_a), 0);
    check("t6_dout_zero", 32'(dout_a), 0);
    check("t6_flags_zero", {28'd0, we_a, fd_a, le_a, ov_a}, 0);
    check("t6_cnt_zero", 32'(fc_a), 0);
    check("t6_drained", q_a.size(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (i == 2) rst_n = 1'b1;
      d = (i % 2 == 0) ? 8'hF8 : 8'h1F;
    end
    href = 1'b0;
    base_we = n_we_a;
    repeat (3) @(negedge pclk);
    vsync = 1'b1;
    repeat (6) @(negedge pclk);
    check("t6_no_we", n_we_a - base_we, 0);
    run_frame(0, 1, 4, 8'h12, 8'h34, 16'h014A, 0, 64, 1);
    post("t6_resume", 0, 2, 1, 1, 2, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
